// File: rtl/core_pkg.sv
// Shared definitions for the core-side merge point: parity sizing, the
// Hamming SEC encoder and the local source tag.
package core_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_PKT_W  = 71;
  localparam int SRC_LOCAL  = 0;

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int par_width(input int data_w);
    int r;
    r = 0;
    for (int p = 1; p < 32; p++) begin
      if (r == 0 && (1 << p) >= data_w + p + 1) r = p;
    end
    return r;
  endfunction

  // Even-parity Hamming SEC code over positions 1..pkt_w (position p -> bit p-1).
  // Parity at powers of two, data bits fill the rest in ascending order.
  // Width-agnostic: callers slice the low data_w+par_width(data_w) bits.
  function automatic logic [MAX_PKT_W-1:0] hamming_encode(
    input logic [MAX_DATA_W-1:0] data,
    input int                    data_w
  );
    logic [MAX_PKT_W-1:0] code;
    int                   pkt_w;
    int                   di;
    logic                 par;
    code  = '0;
    pkt_w = data_w + par_width(data_w);
    di    = 0;
    for (int p = 1; p <= MAX_PKT_W; p++) begin
      if (p <= pkt_w && (p & (p - 1)) != 0) begin
        code[p-1] = data[di];
        di++;
      end
    end
    for (int k = 0; k < 7; k++) begin
      par = 1'b0;
      for (int p = 1; p <= MAX_PKT_W; p++) begin
        if (p <= pkt_w && ((p >> k) & 1) == 1 && p != (1 << k)) par ^= code[p-1];
      end
      if ((1 << k) <= pkt_w) code[(1<<k)-1] = par;
    end
    return code;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/core_rr_encoder.sv
// Round-robin merge of one local source (Hamming encoded) and NUM_NET
// network sources onto one registered output channel with a source tag.
module core_rr_encoder
  import core_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NUM_NET = 1,
  parameter  int CNT_W   = 16,
  parameter  int ENCODE  = 1,
  localparam int PAR_W   = par_width(DATA_W),
  localparam int PKT_W   = DATA_W + PAR_W,
  localparam int NUM_SRC = NUM_NET + 1,
  localparam int SRC_W   = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     loc_valid,
  output logic                     loc_ready,
  input  logic [DATA_W-1:0]        loc_data,
  input  logic [NUM_NET-1:0]       net_valid,
  output logic [NUM_NET-1:0]       net_ready,
  input  logic [NUM_NET*PKT_W-1:0] net_pkt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PKT_W-1:0]         out_pkt,
  output logic [SRC_W-1:0]         out_src,
  output logic [CNT_W-1:0]         pkt_count
);

  logic [NUM_SRC-1:0]   req_p0;
  logic [NUM_SRC-1:0]   grant_p0;
  logic [NUM_SRC-1:0]   ready_p0;
  logic [SRC_W-1:0]     gidx_p0;
  logic [SRC_W-1:0]     nxt_ptr_p0;
  logic [MAX_PKT_W-1:0] enc_full_p0;
  logic                 enc_unused;
  logic [PKT_W-1:0]     loc_pkt_p0;
  logic [PKT_W-1:0]     sel_pkt_p0;
  logic                 load_p0;
  logic                 xfer_p0;

  logic                 vld_p1;
  logic [PKT_W-1:0]     pkt_p1;
  logic [SRC_W-1:0]     src_p1;
  logic [SRC_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     cnt;

  // ---- stage p0: arbitration, encode, source select ----
  assign req_p0 = {net_valid, loc_valid};

  rr_arbiter #(.N(NUM_SRC), .IDX_W(SRC_W)) u_arb (
    .req       (req_p0),
    .ptr       (rr_ptr),
    .grant     (grant_p0),
    .grant_idx (gidx_p0)
  );

  // The output register can take a new packet when empty or being drained.
  assign load_p0  = !vld_p1 || out_ready;
  assign ready_p0 = (rst_n && load_p0) ? grant_p0 : '0;
  assign xfer_p0  = |ready_p0;

  assign loc_ready = ready_p0[0];
  assign net_ready = ready_p0[NUM_SRC-1:1];

  assign enc_full_p0 = hamming_encode(MAX_DATA_W'(loc_data), DATA_W);
  assign enc_unused  = ^enc_full_p0[MAX_PKT_W-1:PKT_W];
  assign loc_pkt_p0  = (ENCODE != 0) ? enc_full_p0[PKT_W-1:0] : PKT_W'(loc_data);

  assign nxt_ptr_p0 = (gidx_p0 == SRC_W'(NUM_SRC - 1)) ? '0 : gidx_p0 + SRC_W'(1);

  // Route the granted source's packet towards the output register.
  always_comb begin
    sel_pkt_p0 = loc_pkt_p0;
    for (int j = 0; j < NUM_NET; j++) begin
      if (gidx_p0 == SRC_W'(j + 1)) sel_pkt_p0 = net_pkt[j*PKT_W +: PKT_W];
    end
  end

  // ---- stage p1: output register, RR pointer and accept counter ----
  // Load on transfer, bubble when loading with nothing granted, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      pkt_p1 <= '0;
      src_p1 <= SRC_W'(SRC_LOCAL);
      rr_ptr <= '0;
      cnt    <= '0;
    end else if (xfer_p0) begin
      vld_p1 <= 1'b1;
      pkt_p1 <= sel_pkt_p0;
      src_p1 <= gidx_p0;
      rr_ptr <= nxt_ptr_p0;
      cnt    <= cnt + CNT_W'(1);
    end else if (load_p0) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_pkt   = pkt_p1;
  assign out_src   = src_p1;
  assign pkt_count = cnt;

endmodule

// File: tb/tb_core_rr_encoder.sv
// Bench for core_rr_encoder (DATA_W=8, NUM_NET=3, CNT_W=4): directed
// scenarios with literal expectations plus a randomized run checked every
// cycle against a transaction-level reference model.
module tb_core_rr_encoder;

  localparam int DATA_W  = 8;
  localparam int NUM_NET = 3;
  localparam int CNT_W   = 4;
  localparam int PKT_W   = 12;
  localparam int NS      = 4;
  localparam int SRC_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     loc_valid = 1'b0;
  logic                     loc_ready;
  logic [DATA_W-1:0]        loc_data = '0;
  logic [NUM_NET-1:0]       net_valid = '0;
  logic [NUM_NET-1:0]       net_ready;
  logic [NUM_NET*PKT_W-1:0] net_pkt = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [PKT_W-1:0]         out_pkt;
  logic [SRC_W-1:0]         out_src;
  logic [CNT_W-1:0]         pkt_count;

  core_rr_encoder #(.DATA_W(DATA_W), .NUM_NET(NUM_NET), .CNT_W(CNT_W), .ENCODE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .loc_valid (loc_valid),
    .loc_ready (loc_ready),
    .loc_data  (loc_data),
    .net_valid (net_valid),
    .net_ready (net_ready),
    .net_pkt   (net_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pkt   (out_pkt),
    .out_src   (out_src),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the output register should hold.
  logic             m_valid = 1'b0;
  logic [PKT_W-1:0] m_pkt   = '0;
  int               m_src   = 0;
  int               m_ptr   = 0;
  int               m_cnt   = 0;
  logic [NS-1:0]    last_acc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoder model via the syndrome view: parity bit k equals bit k of the
  // XOR of all positions that hold a 1 data bit.
  function automatic logic [PKT_W-1:0] ref_enc(input logic [DATA_W-1:0] d);
    logic [PKT_W-1:0] c;
    int syn;
    int di;
    c = '0; syn = 0; di = 0;
    for (int p = 1; p <= PKT_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[di];
        if (d[di]) syn = syn ^ p;
        di++;
      end
    end
    for (int k = 0; k < 4; k++) c[(1<<k)-1] = syn[k];
    return c;
  endfunction

  // Every falling edge: compare DUT against model, then advance the model
  // with the inputs that the coming rising edge will see.
  initial forever begin
    logic [NS-1:0] req;
    logic [NS-1:0] rdy;
    logic          load;
    int            win;
    int            s;
    @(negedge clk);
    rdy = {net_ready, loc_ready};
    req = {net_valid, loc_valid};
    if (!rst_n) begin
      m_valid = 1'b0; m_pkt = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
      last_acc = '0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pkt", out_pkt, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_readies", rdy, 0);
    end else begin
      chk("cyc_out_valid", out_valid, m_valid);
      chk("cyc_out_pkt", out_pkt, m_pkt);
      chk("cyc_out_src", out_src, m_src);
      chk("cyc_pkt_count", pkt_count, m_cnt);
      load = !m_valid || out_ready;
      win = -1;
      for (int k = 0; k < NS; k++) begin
        s = (m_ptr + k) % NS;
        if (win < 0 && req[s]) win = s;
      end
      chk("cyc_readies", rdy, (load && win >= 0) ? (64'd1 << win) : 64'd0);
      last_acc = req & rdy;
      if (load) begin
        if (win >= 0) begin
          m_valid = 1'b1;
          m_pkt   = (win == 0) ? ref_enc(loc_data) : net_pkt[(win-1)*PKT_W +: PKT_W];
          m_src   = win;
          m_ptr   = (win + 1) % NS;
          m_cnt   = (m_cnt + 1) % 16;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [PKT_W-1:0] v;

    chk("model_enc_a5", ref_enc(8'hA5), 12'hA27);
    chk("model_enc_00", ref_enc(8'h00), 12'h000);

    for (int j = 0; j < NUM_NET; j++) net_pkt[j*PKT_W +: PKT_W] = PKT_W'($urandom);

    // Reset state
    repeat (3) tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_pkt_count", pkt_count, 0);
    rst_n = 1'b1;

    // Local encode
    loc_valid = 1'b1; loc_data = 8'hA5;
    tick();
    chk("enc_a5_valid", out_valid, 1);
    chk("enc_a5_pkt", out_pkt, 12'hA27);
    chk("enc_a5_src", out_src, 0);
    loc_data = 8'h00;
    tick();
    chk("enc_00_pkt", out_pkt, 12'h000);
    loc_valid = 1'b0;
    tick();
    chk("bubble_valid", out_valid, 0);

    // Reset mid-stream with a packet held in the output register
    out_ready = 1'b0; loc_valid = 1'b1; loc_data = 8'h3C;
    tick();
    chk("pre_reset_valid", out_valid, 1);
    net_valid = 3'b111;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_count", pkt_count, 0);
    chk("async_rst_ready", {net_ready, loc_ready}, 0);
    out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;

    // Contention: all four sources valid, full throughput rotation
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rot_valid", out_valid, 1);
      chk("rot_src", out_src, i % NS);
    end
    chk("rot_count", pkt_count, 6);

    // Backpressure: output stuck on net channel 0 (src 1)
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_src", out_src, 1);
      chk("bp_pkt", out_pkt, net_pkt[0 +: PKT_W]);
      chk("bp_readies", {net_ready, loc_ready}, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_src", out_src, 2);
    chk("bp_release_pkt", out_pkt, net_pkt[PKT_W +: PKT_W]);

    // Sole requester: net channel 1 served every cycle
    loc_valid = 1'b0; net_valid = 3'b010;
    for (int i = 0; i < 4; i++) begin
      v = PKT_W'($urandom);
      net_pkt[PKT_W +: PKT_W] = v;
      tick();
      chk("sole_src", out_src, 2);
      chk("sole_pkt", out_pkt, v);
      chk("sole_valid", out_valid, 1);
    end

    // Counter wrap: 17 transfers from reset on a 4-bit counter
    net_valid = '0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; loc_valid = 1'b1;
    repeat (17) tick();
    loc_valid = 1'b0;
    chk("wrap_count", pkt_count, 1);
    tick();

    // Randomized traffic; a pending (valid, not yet accepted) source holds.
    for (int c = 0; c < 500; c++) begin
      if (c == 250) rst_n = 1'b0;
      if (c == 253) rst_n = 1'b1;
      if (!(loc_valid && !last_acc[0])) begin
        loc_valid = ($urandom_range(0, 9) < 6);
        loc_data  = DATA_W'($urandom);
      end
      for (int j = 0; j < NUM_NET; j++) begin
        if (!(net_valid[j] && !last_acc[j+1])) begin
          net_valid[j] = ($urandom_range(0, 9) < 5);
          net_pkt[j*PKT_W +: PKT_W] = PKT_W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_rr_encoder.md
Name: core_rr_encoder

Overview:
- Clocked, parametrised successor of the core-side merge point between the local data generator and router ingress.
- Round-robin arbitrates one local source plus NUM_NET network sources onto one registered output channel.
- Local payloads are Hamming SEC encoded on the way through; network packets pass unchanged.
- Each output packet carries a source tag (the generalised "control" signal) for downstream steering.

Parameters:
- DATA_W, 8: local payload width.
- NUM_NET, 1: number of network input channels (>=1).
- CNT_W, 16: width of the accepted-packet counter.
- ENCODE, 1: 1 = Hamming-encode local payloads; 0 = zero-extend payload into PKT_W, no parity.
- Derived localparams:
  - PAR_W = smallest P with 2^P >= DATA_W+P+1 (4 for DATA_W=8).
  - PKT_W = DATA_W+PAR_W.
  - NUM_SRC = NUM_NET+1.
  - SRC_W = max(1, clog2(NUM_SRC)).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- loc_valid  in  1  local payload valid.
- loc_ready  out  1  local payload accepted this cycle when high with loc_valid.
- loc_data  in  DATA_W  local payload.
- net_valid  in  NUM_NET  per-channel valid.
- net_ready  out  NUM_NET  per-channel accept.
- net_pkt  in  NUM_NET*PKT_W  packed packets; channel j occupies [j*PKT_W +: PKT_W].
- out_valid  out  1  output packet valid.
- out_ready  in  1  downstream accept.
- out_pkt  out  PKT_W  output packet.
- out_src  out  SRC_W  source tag: 0 = local, j+1 = net channel j.
- pkt_count  out  CNT_W  total packets accepted since reset.

Behaviour:
- Reset (async assert, sync-safe release): out_valid=0, out_pkt=0, out_src=0, pkt_count=0, RR pointer=0. All ready outputs are 0 while rst_n=0.
- Source index: 0 = local, i = net channel i-1.
- Handshake:
  - A transfer occurs when valid && ready are high on the same rising edge.
  - Senders hold data stable while valid is high until accepted.
  - Readies depend combinationally on valids and out_ready; valids never depend on readies.
- Load condition: load = !out_valid || out_ready. This gives full throughput of one packet per cycle.
- Arbitration (combinational):
  - Scan sources starting at the RR pointer, wrapping modulo NUM_SRC.
  - The first valid source is granted. The winner's ready = load; all other readies = 0.
  - At most one ready is high in any cycle.
- Pointer update: on a transfer from source g, pointer <= (g+1) mod NUM_SRC. With no transfer, the pointer holds. A sole requester is therefore served every cycle. Contending requesters are served in strict rotation (with NUM_NET=1, this alternates 0,1,0,1).
- Output register: on a transfer, at the next edge out_valid=1, out_pkt=encoded/forwarded packet, out_src=g. Latency is exactly 1 cycle from acceptance to out_valid.
- When load=1 and no source is valid: out_valid <= 0 (bubble); out_pkt/out_src hold their values.
- Backpressure: while out_valid && !out_ready, out_pkt and out_src are held bit-stable, all readies are 0, and the pointer holds.
- Hamming encode (ENCODE=1):
  - Bit positions are 1..PKT_W, with position p mapped to out_pkt[p-1].
  - Parity bits sit at powers of two. Data bits fill the remaining positions in ascending order, d0 first.
  - Parity at position 2^k = XOR of all data positions whose index has bit k set (even parity).
  - Example, DATA_W=8: 8'hA5 -> 12'hA27.
- ENCODE=0: out_pkt = {PAR_W'b0, loc_data}.
- pkt_count increments by 1 on every input transfer and wraps modulo 2^CNT_W with no saturation.
- Reset mid-operation: an in-flight output packet is discarded (out_valid drops asynchronously), and the pointer returns to 0.

Decomposition:
- Package core_pkg:
  - function par_width(data_w);
  - function hamming_encode (parametrised by DATA_W via a constant-width wrapper or a parametrised class static);
  - source-tag constant SRC_LOCAL=0.
- Sub-module rr_arbiter:
  - parameter N;
  - ports: req[N], pointer in, grant[N] one-hot, grant_idx.
  - Combinational; the pointer register stays in core_rr_encoder.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, pkt_count=0, loc_ready=net_ready=0 immediately; first grant after release goes to source 0 when all are valid.
- Local encode: DATA_W=8, loc_data=8'hA5 accepted at edge t -> out_valid=1, out_pkt=12'hA27, out_src=0 after edge t+1; loc_data=8'h00 -> 12'h000.
- Contention: NUM_NET=3, all valids held high, out_ready=1 -> out_src sequence 0,1,2,3,0,1; one packet per cycle; pkt_count=6 after 6 transfers.
- Backpressure: out_ready=0 for 5 cycles with all sources valid -> out_pkt/out_src stable, all readies 0, pointer unchanged; on release the next source in rotation is served.
- Sole requester: only net channel 1 valid for 4 cycles -> 4 consecutive transfers, out_src=2, packets forwarded bit-exact.
- Counter wrap: CNT_W=4, 17 transfers -> pkt_count=1.
